usb_txn_scheduler: RTL and testbench



---
 rtl/usb_txn_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_usb_txn_scheduler.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_txn_scheduler.sv
// usb_txn_scheduler: shares one read/write transaction engine between two
// requesters with round-robin grant, per-attempt timeout and bounded retry.
module usb_txn_scheduler #(
   parameter int unsigned MAX_RETRY = 2,
   parameter int unsigned TIMEOUT   = 4096
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  req_valid,
   input  logic [1:0]  req_write,
   input  logic [15:0] req_mempage0,
   input  logic [15:0] req_mempage1,
   input  logic [63:0] req_wdata0,
   input  logic [63:0] req_wdata1,
   output logic [1:0]  done,
   output logic        resp_success,
   output logic        resp_timeout,
   output logic [63:0] resp_rdata,
   output logic        busy,
   output logic        read_start,
   output logic        write_start,
   output logic [15:0] read_mempage,
   output logic [15:0] write_mempage,
   output logic [63:0] write_data,
   input  logic        finished,
   input  logic        read_success,
   input  logic        write_success,
   input  logic [63:0] read_data
);

   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_RESP  = 3'd3;
   localparam logic [2:0] S_DRAIN = 3'd4;

   logic [2:0]    state, state_nx;
   logic          last_grant, last_grant_nx;
   logic          grant, grant_nx;
   logic          op, op_nx;
   logic [15:0]   page, page_nx;
   logic [63:0]   wdata, wdata_nx;
   logic [RW-1:0] retry_cnt, retry_cnt_nx;
   logic          retry_flag, retry_flag_nx;
   logic [TW-1:0] timer, timer_nx;

   logic [1:0]    done_nx;
   logic          resp_success_nx, resp_timeout_nx;
   logic [63:0]   resp_rdata_nx;
   logic          busy_nx, read_start_nx, write_start_nx;

   logic          grant_sel, attempt_end, attempt_ok;

   // Engine addressing comes straight from the grant-time latches.
   assign read_mempage  = page;
   assign write_mempage = page;
   assign write_data    = wdata;

   // Next-state, latch and registered-output computation.
   always_comb begin
      state_nx        = state;
      last_grant_nx   = last_grant;
      grant_nx        = grant;
      op_nx           = op;
      page_nx         = page;
      wdata_nx        = wdata;
      retry_cnt_nx    = retry_cnt;
      retry_flag_nx   = retry_flag;
      timer_nx        = timer;
      done_nx         = 2'b00;
      resp_success_nx = resp_success;
      resp_timeout_nx = resp_timeout;
      resp_rdata_nx   = resp_rdata;
      grant_sel       = 1'b0;
      attempt_end     = 1'b0;
      attempt_ok      = 1'b0;

      case (state)
         S_IDLE: begin
            if (|req_valid) begin
               // On a tie the requester not served last wins.
               grant_sel     = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
               grant_nx      = grant_sel;
               last_grant_nx = grant_sel;
               op_nx         = req_write[grant_sel];
               page_nx       = grant_sel ? req_mempage1 : req_mempage0;
               wdata_nx      = grant_sel ? req_wdata1 : req_wdata0;
               retry_cnt_nx  = '0;
               retry_flag_nx = 1'b0;
               state_nx      = S_ISSUE;
            end
         end
         S_ISSUE: begin
            timer_nx = '0;
            state_nx = S_WAIT;
         end
         S_WAIT: begin
            timer_nx    = timer + TW'(1);
            attempt_end = finished || (timer == TW'(TIMEOUT - 1));
            attempt_ok  = finished && (op ? write_success : read_success);
            if (attempt_end) begin
               if (attempt_ok || (retry_cnt == RW'(MAX_RETRY))) begin
                  state_nx        = S_RESP;
                  done_nx         = grant ? 2'b10 : 2'b01;
                  resp_success_nx = attempt_ok;
                  resp_timeout_nx = !finished;
                  resp_rdata_nx   = (op || !finished) ? 64'd0 : read_data;
               end else begin
                  retry_cnt_nx  = retry_cnt + RW'(1);
                  retry_flag_nx = 1'b1;
                  state_nx      = S_DRAIN;
               end
            end
         end
         S_RESP: begin
            state_nx = S_DRAIN;
         end
         S_DRAIN: begin
            // Never restart the engine while it still reports finished.
            if (!finished) begin
               if (retry_flag) begin
                  retry_flag_nx = 1'b0;
                  state_nx      = S_ISSUE;
               end else begin
                  state_nx = S_IDLE;
               end
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase

      busy_nx        = (state_nx != S_IDLE);
      read_start_nx  = (state_nx == S_ISSUE) && !op_nx;
      write_start_nx = (state_nx == S_ISSUE) && op_nx;
   end

   // State, latches and outputs; synchronous reset clears everything.
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= S_IDLE;
         last_grant   <= 1'b1;
         grant        <= 1'b0;
         op           <= 1'b0;
         page         <= '0;
         wdata        <= '0;
         retry_cnt    <= '0;
         retry_flag   <= 1'b0;
         timer        <= '0;
         done         <= 2'b00;
         resp_success <= 1'b0;
         resp_timeout <= 1'b0;
         resp_rdata   <= '0;
         busy         <= 1'b0;
         read_start   <= 1'b0;
         write_start  <= 1'b0;
      end else begin
         state        <= state_nx;
         last_grant   <= last_grant_nx;
         grant        <= grant_nx;
         op           <= op_nx;
         page         <= page_nx;
         wdata        <= wdata_nx;
         retry_cnt    <= retry_cnt_nx;
         retry_flag   <= retry_flag_nx;
         timer        <= timer_nx;
         done         <= done_nx;
         resp_success <= resp_success_nx;
         resp_timeout <= resp_timeout_nx;
         resp_rdata   <= resp_rdata_nx;
         busy         <= busy_nx;
         read_start   <= read_start_nx;
         write_start  <= write_start_nx;
      end
   end

endmodule

// File: tb/tb_usb_txn_scheduler.sv
// Bench for usb_txn_scheduler: scripted/random engine and requesters,
// cycle-timeline reference model, plus directed literal expectations.
module tb_usb_txn_scheduler;

   localparam int TO = 16;
   localparam int MR = 2;

   logic        clock;
   logic        reset;
   logic [1:0]  req_valid, req_write;
   logic [15:0] req_mempage0, req_mempage1;
   logic [63:0] req_wdata0, req_wdata1;
   logic [1:0]  done;
   logic        resp_success, resp_timeout;
   logic [63:0] resp_rdata;
   logic        busy, read_start, write_start;
   logic [15:0] read_mempage, write_mempage;
   logic [63:0] write_data;
   logic        finished, read_success, write_success;
   logic [63:0] read_data;

   usb_txn_scheduler #(.MAX_RETRY(MR), .TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_write(req_write),
      .req_mempage0(req_mempage0), .req_mempage1(req_mempage1),
      .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
      .done(done), .resp_success(resp_success), .resp_timeout(resp_timeout),
      .resp_rdata(resp_rdata), .busy(busy),
      .read_start(read_start), .write_start(write_start),
      .read_mempage(read_mempage), .write_mempage(write_mempage),
      .write_data(write_data),
      .finished(finished), .read_success(read_success),
      .write_success(write_success), .read_data(read_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      int          lat;    // cycles from start to finished; 0 = never
      int          hold;   // cycles finished stays high
      bit          ok;
      logic [63:0] data;
   } beh_t;

   beh_t script_q[$];
   int   order_q[$];
   int   start_q[$];

   int n_chk = 0;
   int n_fail = 0;

   // stimulus-side state
   int  sc = 0;
   int  n_starts = 0;
   bit  keep_req = 0;
   bit  rand_req = 0;
   int  fin_s = -1, fin_e = -1;
   bit  eng_w = 0, eng_ok = 0;
   logic [63:0] eng_data = '0;
   logic [1:0]  ob_done;
   logic        ob_busy, ob_rs, ob_ws, ob_succ, ob_to;
   logic [63:0] ob_rdata;
   logic [15:0] ob_rpage;

   task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (time %0t)", nm, a, e, $time);
      end
   endtask

   task automatic bound_fail(input string nm, input int budget);
      n_chk++;
      n_fail++;
      $display("FAIL %s: no event within %0d cycles (time %0t)", nm, budget, $time);
   endtask

   function automatic beh_t rand_beh();
      beh_t b;
      int r;
      r = int'($urandom_range(15));
      if (r < 2)       b.lat = 0;
      else if (r == 2) b.lat = TO;
      else if (r == 3) b.lat = TO + 1;
      else             b.lat = int'($urandom_range(6, 1));
      b.hold = int'($urandom_range(3, 1));
      b.ok   = ($urandom_range(2) != 0);
      b.data = {$urandom, $urandom};
      return b;
   endfunction

   task automatic push_beh(input int lat, input int hold, input bit ok, input logic [63:0] data);
      beh_t b;
      b.lat = lat; b.hold = hold; b.ok = ok; b.data = data;
      script_q.push_back(b);
   endtask

   task automatic new_fields(input int i);
      req_write[i] = 1'($urandom_range(1));
      if (i == 0) begin
         req_mempage0 = 16'($urandom);
         req_wdata0   = {$urandom, $urandom};
      end else begin
         req_mempage1 = 16'($urandom);
         req_wdata1   = {$urandom, $urandom};
      end
   endtask

   // One clock: observe this cycle's outputs, then drive requesters/engine.
   task automatic step(input bit rst);
      beh_t b;
      @(posedge clock);
      #1;
      sc++;
      ob_done = done; ob_busy = busy; ob_rs = read_start; ob_ws = write_start;
      ob_succ = resp_success; ob_to = resp_timeout; ob_rdata = resp_rdata;
      ob_rpage = read_mempage;
      if (read_start || write_start) begin
         n_starts++;
         start_q.push_back(sc);
      end
      for (int i = 0; i < 2; i++) begin
         if (done[i]) begin
            order_q.push_back(i);
            if (keep_req || (rand_req && $urandom_range(1) == 0)) new_fields(i);
            else req_valid[i] = 1'b0;
         end else if (rand_req && !req_valid[i] && $urandom_range(3) == 0) begin
            req_valid[i] = 1'b1;
            new_fields(i);
         end else if (rand_req && req_valid[i] && $urandom_range(7) == 0) begin
            new_fields(i);
         end
      end
      if (rst) begin
         fin_s = -1;
      end else if (read_start || write_start) begin
         eng_w = write_start;
         if (script_q.size() > 0) b = script_q.pop_front();
         else b = rand_beh();
         if (b.lat == 0) fin_s = -1;
         else begin
            fin_s = sc + b.lat;
            fin_e = fin_s + b.hold - 1;
         end
         eng_ok   = b.ok;
         eng_data = b.data;
      end
      finished = !rst && (fin_s >= 0) && (sc >= fin_s) && (sc <= fin_e);
      if (finished) begin
         read_success  = eng_w ? ~eng_ok : eng_ok;
         write_success = eng_w ? eng_ok : ~eng_ok;
         read_data     = eng_data;
      end else begin
         read_success  = 1'($urandom_range(1));
         write_success = 1'($urandom_range(1));
         read_data     = {$urandom, $urandom};
      end
      reset = rst;
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) step(1'b1);
      step(1'b0);
   endtask

   task automatic run_until_start(input string nm, input int budget, output int cyc, output bit hit);
      hit = 0; cyc = -1;
      for (int i = 0; i < budget; i++) begin
         step(1'b0);
         if (ob_rs || ob_ws) begin hit = 1; cyc = sc; break; end
      end
      if (!hit) bound_fail(nm, budget);
   endtask

   task automatic run_until_done(input string nm, input int budget, output int cyc, output bit hit);
      hit = 0; cyc = -1;
      for (int i = 0; i < budget; i++) begin
         step(1'b0);
         if (ob_done != 2'b00) begin hit = 1; cyc = sc; break; end
      end
      if (!hit) bound_fail(nm, budget);
   endtask

   // ---------------- reference model (cycle timeline arithmetic) ----------------
   int  mc = 0;
   bit  started = 0;
   bit  m_rstp = 0;
   bit  m_act = 0;
   int  m_g = 0, m_last = 1;
   bit  m_op = 0;
   logic [15:0] m_pg = '0;
   logic [63:0] m_wd = '0;
   int  m_next = -1, m_att = -1, m_tries = 0, m_drain = -1, m_done = -1;
   bit  m_wait = 0, m_retry = 0, m_es = 0, m_et = 0;
   logic [63:0] m_erd = '0;

   // Compare against the model mid-cycle, then advance it with this cycle's inputs.
   always @(negedge clock) begin
      bit ok;
      bit to;
      int g;
      mc++;
      if (started) begin
         chk("busy", 64'(busy), 64'(m_act));
         chk("read_start", 64'(read_start), 64'((mc == m_next) && !m_op));
         chk("write_start", 64'(write_start), 64'((mc == m_next) && m_op));
         chk("done", 64'(done), (mc == m_done) ? (m_g == 1 ? 64'd2 : 64'd1) : 64'd0);
         if (mc == m_done) begin
            chk("resp_success", 64'(resp_success), 64'(m_es));
            chk("resp_timeout", 64'(resp_timeout), 64'(m_et));
            if (m_op || m_es) chk("resp_rdata", resp_rdata, m_erd);
         end
         if (m_rstp) begin
            chk("rst_resp", {62'd0, resp_success, resp_timeout}, 64'd0);
            chk("rst_rdata", resp_rdata, 64'd0);
            chk("rst_pages", {32'd0, read_mempage, write_mempage}, 64'd0);
            chk("rst_wdata", write_data, 64'd0);
         end
         if (m_act) begin
            if (m_op) begin
               chk("write_mempage", 64'(write_mempage), 64'(m_pg));
               chk("write_data", write_data, m_wd);
            end else begin
               chk("read_mempage", 64'(read_mempage), 64'(m_pg));
            end
         end
      end
      if (reset) begin
         started = 1; m_rstp = 1; m_act = 0; m_last = 1;
         m_next = -1; m_done = -1; m_drain = -1; m_wait = 0; m_retry = 0;
      end else begin
         m_rstp = 0;
         if (!m_act) begin
            if (req_valid != 2'b00) begin
               if (req_valid == 2'b11) g = 1 - m_last;
               else g = req_valid[1] ? 1 : 0;
               m_last = g; m_g = g;
               m_op = req_write[g];
               m_pg = (g == 1) ? req_mempage1 : req_mempage0;
               m_wd = (g == 1) ? req_wdata1 : req_wdata0;
               m_tries = 0; m_act = 1; m_next = mc + 1;
            end
         end else if (mc == m_next) begin
            m_tries++; m_att = mc; m_wait = 1; m_next = -1;
         end else if (m_wait) begin
            ok = 0; to = 0;
            if (finished) begin
               ok = m_op ? write_success : read_success;
               m_wait = 0;
            end else if (mc == m_att + TO) begin
               to = 1;
               m_wait = 0;
            end
            if (!m_wait) begin
               if (ok || m_tries == MR + 1) begin
                  m_done = mc + 1; m_es = ok; m_et = to;
                  m_erd = m_op ? 64'd0 : read_data;
                  m_drain = mc + 2; m_retry = 0;
               end else begin
                  m_drain = mc + 1; m_retry = 1;
               end
            end
         end else if (m_drain >= 0 && mc >= m_drain && !finished) begin
            m_drain = -1;
            if (m_retry) begin
               m_retry = 0; m_next = mc + 1;
            end else begin
               m_act = 0;
            end
         end
      end
   end

   // ---------------- directed + random stimulus ----------------
   initial begin
      int r, st, dc, rc;
      bit hit;
      int s0;
      int exp_ord[4];
      exp_ord = '{0, 1, 0, 1};
      reset = 1'b1; req_valid = 2'b00; req_write = 2'b00;
      req_mempage0 = '0; req_mempage1 = '0; req_wdata0 = '0; req_wdata1 = '0;
      finished = 1'b0; read_success = 1'b0; write_success = 1'b0; read_data = '0;

      // reset state
      do_reset(2);
      chk("rst_busy", 64'(ob_busy), 64'd0);
      chk("rst_done", 64'(ob_done), 64'd0);
      chk("rst_starts", {62'd0, ob_rs, ob_ws}, 64'd0);

      // single read on requester 0
      req_write = 2'b00; req_mempage0 = 16'h0012;
      push_beh(2, 1, 1'b1, 64'hDEADBEEF_CAFEF00D);
      req_valid = 2'b01; r = sc;
      run_until_start("t1_start", 10, st, hit);
      if (hit) begin
         chk("t1_start_lat", 64'(st - r), 64'd1);
         chk("t1_read_start", 64'(ob_rs), 64'd1);
         chk("t1_write_start", 64'(ob_ws), 64'd0);
         chk("t1_page", 64'(ob_rpage), 64'h0012);
      end
      run_until_done("t1_done", 20, dc, hit);
      if (hit) begin
         chk("t1_done_bits", 64'(ob_done), 64'd1);
         chk("t1_success", 64'(ob_succ), 64'd1);
         chk("t1_rdata", ob_rdata, 64'hDEADBEEF_CAFEF00D);
         chk("t1_latency", 64'(dc - r), 64'd4);
      end
      for (int i = 0; i < 4; i++) step(1'b0);

      // tie arbitration with immediate re-request
      req_valid = 2'b11; req_write = 2'b00; keep_req = 1; order_q.delete();
      do_reset(1);
      for (int i = 0; i < 600 && order_q.size() < 4; i++) step(1'b0);
      if (order_q.size() < 4) bound_fail("t2_order", 600);
      else for (int i = 0; i < 4; i++) chk("t2_order", 64'(order_q[i]), 64'(exp_ord[i]));
      keep_req = 0; req_valid = 2'b00;
      do_reset(1);

      // write: two failures then success
      req_write = 2'b01; req_mempage0 = 16'h0BEE; req_wdata0 = 64'h0123_4567_89AB_CDEF;
      push_beh(1, 2, 1'b0, 64'd0);
      push_beh(3, 1, 1'b0, 64'd0);
      push_beh(2, 1, 1'b1, 64'd0);
      s0 = n_starts; req_valid = 2'b01;
      run_until_done("t3_done", 100, dc, hit);
      if (hit) begin
         chk("t3_starts", 64'(n_starts - s0), 64'd3);
         chk("t3_done_bits", 64'(ob_done), 64'd1);
         chk("t3_success", 64'(ob_succ), 64'd1);
         chk("t3_timeout", 64'(ob_to), 64'd0);
         chk("t3_rdata", ob_rdata, 64'd0);
         chk("t3_wdata", write_data, 64'h0123_4567_89AB_CDEF);
      end
      for (int i = 0; i < 4; i++) step(1'b0);

      // read on requester 1, every attempt fails
      req_write = 2'b00; req_mempage1 = 16'hF00F;
      for (int i = 0; i < 3; i++) push_beh(2, 1, 1'b0, 64'h5555);
      s0 = n_starts; req_valid = 2'b10;
      run_until_done("t4_done", 100, dc, hit);
      if (hit) begin
         chk("t4_starts", 64'(n_starts - s0), 64'd3);
         chk("t4_done_bits", 64'(ob_done), 64'd2);
         chk("t4_success", 64'(ob_succ), 64'd0);
         chk("t4_timeout", 64'(ob_to), 64'd0);
      end
      for (int i = 0; i < 4; i++) step(1'b0);

      // engine never finishes: three timed-out attempts
      req_write = 2'b00; req_mempage0 = 16'h0777;
      for (int i = 0; i < 3; i++) push_beh(0, 1, 1'b0, 64'd0);
      start_q.delete(); req_valid = 2'b01;
      run_until_done("t5_done", 200, dc, hit);
      if (hit) begin
         chk("t5_starts", 64'(start_q.size()), 64'd3);
         if (start_q.size() == 3) begin
            chk("t5_retry_gap", 64'(start_q[1] - start_q[0]), 64'd18);
            chk("t5_total", 64'(dc - start_q[0]), 64'd53);
         end
         chk("t5_success", 64'(ob_succ), 64'd0);
         chk("t5_timeout", 64'(ob_to), 64'd1);
      end
      for (int i = 0; i < 4; i++) step(1'b0);

      // reset during WAIT, held request re-granted
      req_write = 2'b00; req_mempage0 = 16'h0ABC;
      push_beh(0, 1, 1'b0, 64'd0);
      push_beh(2, 1, 1'b1, 64'h1122_3344_5566_7788);
      req_valid = 2'b01;
      for (int i = 0; i < 4; i++) step(1'b0);
      step(1'b1); rc = sc;
      step(1'b0);
      chk("t6_busy", 64'(ob_busy), 64'd0);
      chk("t6_done", 64'(ob_done), 64'd0);
      chk("t6_start", 64'(ob_rs), 64'd0);
      run_until_start("t6_start", 10, st, hit);
      if (hit) chk("t6_regrant", 64'(st - rc), 64'd2);
      run_until_done("t6_done", 20, dc, hit);
      if (hit) begin
         chk("t6_success", 64'(ob_succ), 64'd1);
         chk("t6_rdata", ob_rdata, 64'h1122_3344_5566_7788);
      end

      // randomized traffic with occasional resets
      rand_req = 1;
      for (int i = 0; i < 3000; i++) step($urandom_range(399) == 0);
      rand_req = 0; keep_req = 0;
      hit = 0;
      for (int i = 0; i < 3000; i++) begin
         step(1'b0);
         if (!ob_busy && req_valid == 2'b00) begin hit = 1; break; end
      end
      if (!hit) bound_fail("quiesce", 3000);
      for (int i = 0; i < 3; i++) step(1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
